// File: rtl/sm_mult_pkg.sv
// sm_mult_pkg: shared FSM encoding and sizing for the shift-add multiplier arbiter
package sm_mult_pkg;
  localparam int OPW_DEF = 4;
  localparam int NCLI = 2;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
endpackage

// File: rtl/sm_mult_datapath.sv
// sm_mult_datapath: operand registers, running sum with carry, and the add/shift engine
module sm_mult_datapath
  import sm_mult_pkg::*;
#(
  parameter int OPW = OPW_DEF,
  parameter int CW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_add_en,
  input  logic             i_shift,
  input  logic [CW-1:0]    i_cnt,
  input  logic [OPW-1:0]   i_md,
  input  logic [OPW-1:0]   i_mr,
  output logic [2*OPW-1:0] o_rs
);
  logic [OPW-1:0]   r_md;
  logic [OPW-1:0]   r_mr;
  logic [2*OPW-1:0] r_rs;
  logic             r_carry;
  logic [OPW:0]     w_sum;
  assign w_sum = {1'b0, r_rs[2*OPW-1:OPW]} + {1'b0, r_md};
  assign o_rs = r_rs;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md    <= '0;
      r_mr    <= '0;
      r_rs    <= '0;
      r_carry <= 1'b0;
    end else begin
      if (i_load) begin
        r_md <= i_md;
        r_mr <= i_mr;
      end
      if (i_clear) begin
        r_rs    <= '0;
        r_carry <= 1'b0;
      end else if (i_add_en && r_mr[i_cnt]) begin
        {r_carry, r_rs[2*OPW-1:OPW]} <= w_sum;
      end else if (i_shift) begin
        r_rs    <= {r_carry, r_rs[2*OPW-1:1]};
        r_carry <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sm_mult_arbiter.sv
// sm_mult_arbiter: two-client round-robin front end sequencing a shift-add multiplier
module sm_mult_arbiter
  import sm_mult_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCLI-1:0]  req_valid,
  output logic [NCLI-1:0]  req_ready,
  input  logic [OPW-1:0]   req_md0,
  input  logic [OPW-1:0]   req_mr0,
  input  logic [OPW-1:0]   req_md1,
  input  logic [OPW-1:0]   req_mr1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*OPW-1:0] rsp_product,
  output logic             rsp_id,
  output logic             busy
);
  localparam int CW = (OPW > 1) ? $clog2(OPW) : 1;
  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_last;
  logic             r_id;
  logic             w_pick1;
  logic             w_accept;
  logic             w_add;
  logic             w_shift;
  logic             w_last_iter;
  logic [2*OPW-1:0] w_rs;
  // client 1 wins when it is alone, or on a tie when client 0 was granted last
  assign w_pick1     = req_valid[1] & (~req_valid[0] | ~r_last);
  assign w_accept    = (r_state == IDLE) & rst_n & (|req_valid);
  assign req_ready   = w_accept ? (w_pick1 ? 2'b10 : 2'b01) : 2'b00;
  assign w_last_iter = r_cnt == CW'(OPW - 1);
  assign rsp_valid   = r_state == DONE;
  assign rsp_product = rsp_valid ? w_rs : '0;
  assign rsp_id      = rsp_valid & r_id;
  assign busy        = r_state != IDLE;
  always_comb begin
    w_next  = r_state;
    w_add   = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE: w_next = w_accept ? ADD : IDLE;
      ADD: begin
        w_add  = 1'b1;
        w_next = SHIFT;
      end
      SHIFT: begin
        w_shift = 1'b1;
        w_next  = w_last_iter ? DONE : ADD;
      end
      default: w_next = rsp_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt  <= '0;
        r_last <= w_pick1;
        r_id   <= w_pick1;
      end else if (w_shift && !w_last_iter) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  sm_mult_datapath #(.OPW(OPW), .CW(CW)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_clear  (w_accept),
    .i_add_en (w_add),
    .i_shift  (w_shift),
    .i_cnt    (r_cnt),
    .i_md     (w_pick1 ? req_md1 : req_md0),
    .i_mr     (w_pick1 ? req_mr1 : req_mr0),
    .o_rs     (w_rs)
  );
endmodule

// File: tb/tb_sm_mult_arbiter.sv
// tb_sm_mult_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_sm_mult_arbiter;
  localparam int W = 4;
  localparam int LAT = 2 * W + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [W-1:0] req_md0 = '0, req_mr0 = '0, req_md1 = '0, req_mr1 = '0;
  logic rsp_valid, rsp_id, busy;
  logic rsp_ready = 1'b1;
  logic [2*W-1:0] rsp_product;
  int n_chk = 0, n_pass = 0, cyc_n = 0;
  int m_age = 0, m_prod = 0, m_id = 0;
  logic m_last = 1'b1;
  int acc_t[$], rsp_t[$], rsp_p[$];
  int acc_id[$], rsp_i[$];
  logic [1:0] s_g;
  logic s_rv, s_id, s_busy;
  logic [2*W-1:0] s_p;

  sm_mult_arbiter #(.OPW(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_md0(req_md0), .req_mr0(req_mr0), .req_md1(req_md1), .req_mr1(req_mr1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc_n);
  endtask

  function automatic int winner(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 0 : 1;
    return v[1] ? 1 : 0;
  endfunction

  // Transaction model: m_age counts cycles since the accept; response is due at age LAT
  always @(posedge clk) begin
    cyc_n++;
    if (!rst_n) begin
      m_age = 0;
      m_last = 1'b1;
    end else if (m_age == 0) begin
      if (|req_valid) begin
        m_id = winner(req_valid, m_last);
        m_last = m_id[0];
        m_prod = m_id == 1 ? int'(req_md1) * int'(req_mr1) : int'(req_md0) * int'(req_mr0);
        m_age = 1;
      end
    end else if (m_age < LAT) m_age++;
    else if (rsp_ready) m_age = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_product", rsp_product, 0);
      chk("rst_rsp_id", rsp_id, 0);
    end else begin
      chk("req_ready", req_ready, (m_age == 0 && |req_valid) ? (1 << winner(req_valid, m_last)) : 0);
      chk("busy", busy, int'(m_age != 0));
      chk("rsp_valid", rsp_valid, int'(m_age == LAT));
      if (m_age == LAT) begin
        chk("rsp_product", rsp_product, m_prod);
        chk("rsp_id", rsp_id, m_id);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    s_g = req_ready; s_rv = rsp_valid; s_p = rsp_product; s_id = rsp_id; s_busy = busy;
    if (|s_g) begin acc_t.push_back(cyc_n); acc_id.push_back(int'(s_g[1])); end
    if (s_rv && rsp_ready) begin rsp_t.push_back(cyc_n); rsp_p.push_back(int'(s_p)); rsp_i.push_back(int'(s_id)); end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~s_g;
  endtask

  task automatic clear_q();
    acc_t.delete(); acc_id.delete(); rsp_t.delete(); rsp_p.delete(); rsp_i.delete();
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 80 && rsp_p.size() < n; i++) cyc();
    chk("rsp_count", rsp_p.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t0;
    // tie pending from reset: client 0 first (225), then client 1 (14)
    req_valid = 2'b11; req_md0 = 15; req_mr0 = 15; req_md1 = 2; req_mr1 = 7;
    @(negedge clk);
    chk("reset_req_ready_lit", req_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    t0 = cyc_n;
    clear_q();
    wait_rsp(2);
    chk("tie_first_id", acc_id[0], 0);
    chk("tie_second_id", acc_id[1], 1);
    chk("first_accept_time", acc_t[0], t0);
    chk("p225", rsp_p[0], 225);
    chk("p225_id", rsp_i[0], 0);
    chk("p14", rsp_p[1], 14);
    chk("p14_id", rsp_i[1], 1);
    chk("lat_225", rsp_t[0] - acc_t[0], LAT);
    chk("bubble", acc_t[1] - rsp_t[0], 1);
    // single client 0: 3*5
    clear_q();
    req_md0 = 3; req_mr0 = 5; req_valid = 2'b01;
    t0 = cyc_n;
    cyc();
    chk("same_cycle_ready", s_g, 1);
    chk("same_cycle_t", acc_t[0], t0);
    wait_rsp(1);
    chk("p15", rsp_p[0], 15);
    chk("p15_id", rsp_i[0], 0);
    chk("lat_15", rsp_t[0] - acc_t[0], LAT);
    // second tie after client 0 was served: client 1 first
    clear_q();
    req_md0 = 1; req_mr0 = 1; req_md1 = 4; req_mr1 = 4; req_valid = 2'b11;
    wait_rsp(2);
    chk("tie2_first_id", acc_id[0], 1);
    chk("p16", rsp_p[0], 16);
    chk("p1", rsp_p[1], 1);
    // zero operands still take full latency
    clear_q();
    req_md0 = 0; req_mr0 = 9; req_md1 = 9; req_mr1 = 0; req_valid = 2'b11;
    wait_rsp(2);
    chk("zero_a", rsp_p[0], 0);
    chk("zero_b", rsp_p[1], 0);
    chk("zero_lat_a", rsp_t[0] - acc_t[0], LAT);
    chk("zero_lat_b", rsp_t[1] - acc_t[1], LAT);
    // backpressure in DONE for 5 cycles
    clear_q();
    rsp_ready = 1'b0;
    req_md0 = 1; req_mr0 = 1; req_md1 = 6; req_mr1 = 7; req_valid = 2'b11;
    s_rv = 1'b0;
    for (int i = 0; i < 30 && !s_rv; i++) cyc();
    chk("bp_reached_done", s_rv, 1);
    chk("bp_grant", acc_id[0], 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid", s_rv, 1);
      chk("bp_product", s_p, 42);
      chk("bp_id", s_id, 1);
      chk("bp_ready_zero", s_g, 0);
    end
    rsp_ready = 1'b1;
    cyc();
    cyc();
    chk("bp_idle_busy", s_busy, 0);
    chk("bp_idle_grant", s_g, 1);
    wait_rsp(2);
    chk("bp_p42", rsp_p[0], 42);
    chk("bp_p1", rsp_p[1], 1);
    // reset during SHIFT of iteration 2 aborts silently
    clear_q();
    req_md1 = 5; req_mr1 = 5; req_valid = 2'b10;
    s_g = 2'b00;
    for (int i = 0; i < 5 && s_g == 2'b00; i++) cyc();
    repeat (5) cyc();
    #2;
    rst_n = 1'b0;
    req_md1 = 3; req_mr1 = 4; req_valid = 2'b10;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_ready", req_ready, 0);
    chk("abort_product", rsp_product, 0);
    chk("abort_id", rsp_i.size() + int'(rsp_id), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_rsp(1);
    chk("after_abort_p12", rsp_p[0], 12);
    chk("after_abort_id", rsp_i[0], 1);
    // operands change right after the accept
    clear_q();
    req_md0 = 13; req_mr0 = 11; req_valid = 2'b01;
    s_g = 2'b00;
    for (int i = 0; i < 5 && s_g == 2'b00; i++) cyc();
    req_md0 = 2; req_mr0 = 2;
    wait_rsp(1);
    chk("sampled_p143", rsp_p[0], 143);
    // random traffic checked by the model
    for (int i = 0; i < 500; i++) begin
      if (!req_valid[0] && $urandom_range(0, 2) == 0) req_valid[0] = 1'b1;
      if (!req_valid[1] && $urandom_range(0, 2) == 0) req_valid[1] = 1'b1;
      req_md0 = W'($urandom); req_mr0 = W'($urandom);
      req_md1 = W'($urandom); req_mr1 = W'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (15) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sm_mult_arbiter.md
SM_MULT_ARBITER -- requirements
Module: sm_mult_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the reset SHALL be named rst_n.
REQ-002 The block SHALL have parameter OPW, default 4, giving the operand width in bits; the product width is 2*OPW.
REQ-003 The block SHALL have these ports:
  clk  input  1  clock; all state changes on the rising edge.
  rst_n  input  1  asynchronous active-low reset.
  req_valid  input  2  per-client request valid (bit i = client i).
  req_ready  output  2  per-client accept strobe (combinational, one-hot or zero).
  req_md0  input  OPW  client 0 multiplicand.
  req_mr0  input  OPW  client 0 multiplier.
  req_md1  input  OPW  client 1 multiplicand.
  req_mr1  input  OPW  client 1 multiplier.
  rsp_valid  output  1  product available.
  rsp_ready  input  1  consumer accepts product.
  rsp_product  output  2*OPW  unsigned product md*mr.
  rsp_id  output  1  client index of the product.
  busy  output  1  high in every state except IDLE.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, ADD, SHIFT, DONE.
REQ-005 In IDLE, when any req_valid bit is high, the block SHALL assert req_ready for exactly one granted client in that same cycle; on the next edge it SHALL latch that client's md, mr and id, clear the running sum, clear the carry bit and the iteration counter, and enter ADD.
REQ-006 Arbitration SHALL be round-robin:
  - If only one client is valid, that client SHALL win.
  - If both are valid, the client not granted last SHALL win.
  - last_grant SHALL reset to 1, so client 0 wins the first tie.
REQ-007 In ADD, if mr[cnt] is 1, {carry, rs[2*OPW-1:OPW]} SHALL become rs[2*OPW-1:OPW] + md; otherwise rs SHALL be unchanged. The next state SHALL be SHIFT.
REQ-008 In SHIFT, rs SHALL become {carry, rs[2*OPW-1:1]} and carry SHALL be cleared. If cnt equals OPW-1, the next state SHALL be DONE; otherwise cnt SHALL increment and the next state SHALL be ADD.
REQ-009 The first rsp_valid cycle SHALL occur exactly 2*OPW+1 cycles after the accept cycle (9 cycles for OPW=4).
REQ-010 In DONE, rsp_valid SHALL be high and rsp_product and rsp_id SHALL be stable until the cycle in which rsp_ready is high; the next state SHALL then be IDLE.
REQ-011 In DONE, if rsp_ready is low, the block SHALL hold indefinitely.
REQ-012 req_ready SHALL be 0 in every state except IDLE; requests arriving during ADD, SHIFT or DONE SHALL wait, with one idle-cycle bubble minimum between transactions.
REQ-013 Operand inputs SHALL be sampled only in the accept cycle; later changes SHALL NOT affect the result.
REQ-014 A zero operand SHALL still take the full 2*OPW+1 latency and produce 0.

Reset
REQ-015 While rst_n is low, regardless of the clock, the block SHALL set:
  - state = IDLE
  - rsp_valid = 0, rsp_product = 0, rsp_id = 0
  - busy = 0, req_ready = 0
  - cnt = 0, carry = 0, last_grant = 1
REQ-016 Reset asserted mid-operation SHALL abort the transaction silently, with no response issued.
REQ-017 After rst_n deasserts, the first accept SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-018 The state encoding, OPW default and the client-count constant (2) SHALL live in a shared package, sm_mult_pkg.
REQ-019 The md/mr/rs/carry registers and the adder SHALL be a sub-module, sm_mult_datapath, driven by load, clear, add_en and shift control strobes; the arbiter/FSM SHALL remain in sm_mult_arbiter.

Verification
REQ-020 The bench SHALL cover these scenarios:
  - Client 0 requests md=3, mr=5 -> req_ready=01 the same cycle; rsp_valid 9 cycles later with product=15, id=0.
  - Both clients valid from reset, client 0 md=15 mr=15 and client 1 md=2 mr=7 -> client 0 served first with 225, then client 1 with 14; a second tie grants client 1 first.
  - md=0, mr=9 and md=9, mr=0 -> product=0 after the full 9-cycle latency.
  - rsp_ready held low for 5 cycles in DONE -> rsp_valid, product and id stable; req_ready=00 throughout; IDLE entered the cycle after rsp_ready rises.
  - rst_n pulsed low during SHIFT of iteration 2 -> all outputs 0 immediately; no rsp_valid; the next request completes correctly.
  - Operands changed the cycle after accept -> the product reflects the originally sampled values.
